// File: rtl/codec_init_sequencer.sv
// rtl/codec_init_sequencer.sv - walks a config table and issues one I2C write per entry
module codec_init_sequencer #(
  parameter int NUM_ENTRIES    = 11,
  parameter int IDX_W          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] entry_index,
  input  logic [6:0]       entry_addr,
  input  logic [7:0]       entry_data,
  input  logic             i2c_ready,
  output logic             i2c_enable,
  output logic             i2c_mode,
  output logic [6:0]       i2c_periph_addr,
  output logic [7:0]       i2c_input_byte,
  output logic             busy,
  output logic             done,
  output logic             error
);

  // Counter widths never drop below one bit so GAP_CYCLES=0 or TIMEOUT_CYCLES=1 still elaborate.
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT_ACCEPT,
    ST_WAIT_DONE,
    ST_GAP,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         addr_q, addr_d;
  logic [7:0]         byte_q, byte_d;
  logic               issue_q, issue_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;

  // State and datapath registers; reset returns everything to the idle picture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      byte_q    <= '0;
      issue_q   <= 1'b0;
      gap_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      byte_q    <= byte_d;
      issue_q   <= issue_d;
      gap_cnt_q <= gap_cnt_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  // Next-state logic: one table entry per FETCH..WAIT_DONE pass, GAP between entries.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    byte_d    = byte_q;
    issue_d   = issue_q;
    gap_cnt_d = gap_cnt_q;
    to_cnt_d  = to_cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_FETCH;
        end
      end

      // The table is combinational on entry_index, so one clock is enough to latch it.
      ST_FETCH: begin
        addr_d  = entry_addr;
        byte_d  = entry_data;
        issue_d = 1'b0;
        state_d = ST_ISSUE;
      end

      // issue_q marks the second enable clock.
      ST_ISSUE: begin
        if (issue_q) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT_ACCEPT;
        end else begin
          issue_d = 1'b1;
        end
      end

      // Ready dropping wins over a timeout landing on the same clock.
      ST_WAIT_ACCEPT: begin
        if (!i2c_ready) begin
          to_cnt_d = '0;
          state_d  = ST_WAIT_DONE;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_WAIT_DONE: begin
        if (i2c_ready) begin
          if (idx_q >= LAST_IDX) begin
            state_d = ST_DONE;
          end else if (GAP_CYCLES == 0) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
          end else begin
            gap_cnt_d = '0;
            state_d   = ST_GAP;
          end
        end else if (to_cnt_q == TO_LAST) begin
          state_d = ST_ERROR;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decode straight from state so reset clears them without waiting for a clock.
  always_comb begin
    i2c_enable      = (state_q == ST_ISSUE);
    i2c_mode        = 1'b1;
    busy            = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                      (state_q == ST_WAIT_ACCEPT) || (state_q == ST_WAIT_DONE) ||
                      (state_q == ST_GAP);
    done            = (state_q == ST_DONE);
    error           = (state_q == ST_ERROR);
    entry_index     = idx_q;
    i2c_periph_addr = addr_q;
    i2c_input_byte  = byte_q;
  end

endmodule

// File: tb/tb_codec_init_sequencer.sv
// tb/tb_codec_init_sequencer.sv - scoreboard bench for codec_init_sequencer
module tb_codec_init_sequencer;

  localparam int N0   = 3;
  localparam int GAP0 = 2;
  localparam int TO0  = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start;
  logic       start1;

  // main DUT (3 entries, gap 2)
  logic [3:0] entry_index;
  logic [6:0] entry_addr, periph_addr;
  logic [7:0] entry_data, input_byte;
  logic       i2c_ready = 1'b1;
  logic       i2c_enable, i2c_mode, busy, done, error;

  // second DUT (1 entry, no gap)
  logic [3:0] idx1;
  logic [6:0] eaddr1, paddr1;
  logic [7:0] edata1, byte1;
  logic       rdy1 = 1'b1;
  logic       en1, mode1, busy1, done1, error1;

  logic [6:0] tbl_addr [16];
  logic [7:0] tbl_data [16];

  assign entry_addr = tbl_addr[entry_index];
  assign entry_data = tbl_data[entry_index];
  assign eaddr1     = tbl_addr[idx1];
  assign edata1     = tbl_data[idx1];

  codec_init_sequencer #(.NUM_ENTRIES(N0), .IDX_W(4), .GAP_CYCLES(GAP0), .TIMEOUT_CYCLES(TO0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .entry_index(entry_index),
    .entry_addr(entry_addr), .entry_data(entry_data), .i2c_ready(i2c_ready),
    .i2c_enable(i2c_enable), .i2c_mode(i2c_mode), .i2c_periph_addr(periph_addr),
    .i2c_input_byte(input_byte), .busy(busy), .done(done), .error(error)
  );

  codec_init_sequencer #(.NUM_ENTRIES(1), .IDX_W(4), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO0)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .entry_index(idx1),
    .entry_addr(eaddr1), .entry_data(edata1), .i2c_ready(rdy1),
    .i2c_enable(en1), .i2c_mode(mode1), .i2c_periph_addr(paddr1),
    .i2c_input_byte(byte1), .busy(busy1), .done(done1), .error(error1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Controller model: 0 normal, 1 never accepts, 2 never finishes on hold_entry.
  int ctl_mode   = 0;
  int busy_len   = 20;
  int hold_entry = 0;
  int ctl_cnt    = 0;
  logic ctl_hold = 1'b0;

  always @(posedge clk) begin
    if (ctl_cnt != 0) begin
      if (!(ctl_mode == 2 && ctl_hold)) begin
        ctl_cnt <= ctl_cnt - 1;
        if (ctl_cnt == 1) i2c_ready <= 1'b1;
      end
    end else if (i2c_enable && i2c_ready && ctl_mode != 1) begin
      i2c_ready <= 1'b0;
      ctl_cnt   <= busy_len;
      ctl_hold  <= (int'(entry_index) == hold_entry);
    end
  end

  int c1_cnt = 0;
  always @(posedge clk) begin
    if (c1_cnt != 0) begin
      c1_cnt <= c1_cnt - 1;
      if (c1_cnt == 1) rdy1 <= 1'b1;
    end else if (en1 && rdy1) begin
      rdy1   <= 1'b0;
      c1_cnt <= 6;
    end
  end

  // Scoreboard of writes the main DUT still owes.
  typedef struct {
    int         idx;
    logic [6:0] a;
    logic [7:0] d;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  logic cur_valid = 1'b0;
  int   cyc = 0;
  int   rdy_rise_cyc = 0;
  int   en_len = 0;
  logic en_prev = 1'b0, rdy_prev = 1'b1, done_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (i2c_enable && !en_prev) begin
        en_len = 0;
        if (exp_q.size() == 0) begin
          check("unexpected_enable", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          cur_valid = 1'b1;
          check("txn_index", entry_index, cur.idx);
          check("txn_addr", periph_addr, cur.a);
          check("txn_data", input_byte, cur.d);
          if (cur.idx != 0) check("gap_len", cyc - rdy_rise_cyc, GAP0 + 2);
        end
      end
      if (i2c_enable) en_len++;
      if (!i2c_enable && en_prev) check("enable_len", en_len, 2);
      if (i2c_ready && !rdy_prev && cur_valid) begin
        check("hold_addr", periph_addr, cur.a);
        check("hold_data", input_byte, cur.d);
        rdy_rise_cyc = cyc;
        cur_valid = 1'b0;
      end
      if (done && !done_prev) check("done_latency", cyc - rdy_rise_cyc, 1);
    end else begin
      cur_valid = 1'b0;
    end
    en_prev   = i2c_enable;
    rdy_prev  = i2c_ready;
    done_prev = done;
  end

  task automatic randomize_table();
    for (int i = 0; i < 16; i++) begin
      tbl_addr[i] = 7'($urandom);
      tbl_data[i] = 8'($urandom);
    end
  endtask

  task automatic push_run(input int first, input int last);
    txn_t t;
    for (int i = first; i <= last; i++) begin
      t.idx = i;
      t.a   = tbl_addr[i];
      t.d   = tbl_data[i];
      exp_q.push_back(t);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end();
    int k = 0;
    while (!(done || error) && k < 3000) begin
      @(negedge clk);
      k++;
    end
    if (!(done || error)) check("end_reached", 0, 1);
  endtask

  task automatic check_final(input string tag, input int d, input int e, input int idx);
    check({tag, "_done"}, done, d);
    check({tag, "_error"}, error, e);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_index"}, entry_index, idx);
    check({tag, "_enable"}, i2c_enable, 0);
    check({tag, "_mode"}, i2c_mode, 1);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, n_en, len, rr, dl, falls;
    logic seen, prev, p_en, p_rdy;

    reset  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    randomize_table();
    repeat (3) @(negedge clk);
    check("rst_index", entry_index, 0);
    check("rst_enable", i2c_enable, 0);
    check("rst_mode", i2c_mode, 1);
    check("rst_addr", periph_addr, 0);
    check("rst_data", input_byte, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // three-entry run with the reference 20-clock controller
    busy_len = 20;
    push_run(0, N0 - 1);
    pulse_start();
    wait_end();
    check_final("run20", 1, 0, N0 - 1);

    // random tables and controller latencies
    for (int r = 0; r < 4; r++) begin
      randomize_table();
      busy_len = $urandom_range(30, 2);
      push_run(0, N0 - 1);
      pulse_start();
      wait_end();
      check_final("runrand", 1, 0, N0 - 1);
    end

    // controller never accepts: timeout in WAIT_ACCEPT
    ctl_mode = 1;
    randomize_table();
    push_run(0, 0);
    pulse_start();
    n = 0; seen = 1'b0; prev = 1'b0;
    for (int j = 0; j < TO0 + 50; j++) begin
      @(negedge clk);
      if (prev && !i2c_enable) seen = 1'b1;
      if (seen) begin
        if (error) break;
        n++;
      end
      prev = i2c_enable;
    end
    check("timeout_len", n, TO0);
    check_final("accept_to", 0, 1, 0);
    ctl_mode = 0;

    // controller stalls on entry 1: timeout in WAIT_DONE, then restart
    ctl_mode   = 2;
    hold_entry = 1;
    busy_len   = 10;
    randomize_table();
    push_run(0, 1);
    pulse_start();
    wait_end();
    check_final("done_to", 0, 1, 1);
    ctl_mode = 0;
    k = 0;
    while (!i2c_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("ready_back", i2c_ready, 1);
    randomize_table();
    push_run(0, N0 - 1);
    pulse_start();
    check("restart_error_clr", error, 0);
    check("restart_busy", busy, 1);
    check("restart_index", entry_index, 0);
    wait_end();
    check_final("after_err", 1, 0, N0 - 1);

    // start held high across two complete runs
    randomize_table();
    busy_len = $urandom_range(15, 3);
    push_run(0, N0 - 1);
    push_run(0, N0 - 1);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    wait_end();
    check("held_first_done", done, 1);
    @(negedge clk);
    check("held_relaunch", busy, 1);
    wait_end();
    start = 1'b0;
    check_final("held", 1, 0, N0 - 1);
    repeat (3) @(negedge clk);
    check("held_stays_done", done, 1);

    // reset in the middle of the third write
    busy_len = 30;
    randomize_table();
    push_run(0, N0 - 1);
    pulse_start();
    falls = 0; prev = 1'b0; k = 0;
    while (falls < 3 && k < 1000) begin
      @(negedge clk);
      if (prev && !i2c_enable) falls++;
      prev = i2c_enable;
      k++;
    end
    check("reached_entry2", falls, 3);
    repeat (3) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("async_index", entry_index, 0);
    check("async_enable", i2c_enable, 0);
    check("async_mode", i2c_mode, 1);
    check("async_addr", periph_addr, 0);
    check("async_data", input_byte, 0);
    check("async_busy", busy, 0);
    check("async_done", done, 0);
    check("async_error", error, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (60) @(negedge clk);
    check("post_reset_busy", busy, 0);
    check("post_reset_index", entry_index, 0);
    check("post_reset_queue", exp_q.size(), 0);

    // single entry, zero gap on the second instance
    randomize_table();
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    n_en = 0; len = 0; rr = 0; dl = -1; p_en = 1'b0; p_rdy = 1'b1;
    for (int j = 0; j < 200; j++) begin
      @(negedge clk);
      if (en1) begin
        if (!p_en) begin
          n_en++;
          check("g0_addr", paddr1, tbl_addr[0]);
          check("g0_data", byte1, tbl_data[0]);
        end
        len++;
      end
      if (rdy1 && !p_rdy) rr = j;
      if (done1 && dl < 0) dl = j - rr;
      p_en  = en1;
      p_rdy = rdy1;
    end
    check("g0_enables", n_en, 1);
    check("g0_enable_len", len, 2);
    check("g0_done_latency", dl, 1);
    check("g0_done", done1, 1);
    check("g0_error", error1, 0);
    check("g0_index", idx1, 0);
    check("g0_mode", mode1, 1);
    check("g0_busy", busy1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/codec_init_sequencer.md
CODEC_INIT_SEQUENCER -- requirements
Module: codec_init_sequencer

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 11: number of table entries to write (1..2**IDX_W).
REQ-002 SHALL have parameter IDX_W, default 4: width of the table index.
REQ-003 SHALL have parameter GAP_CYCLES, default 16: idle clocks between consecutive writes (0 allowed).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096: maximum clocks allowed in any wait state.
REQ-005 SHALL have port clk  input  1  single system clock, rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  level; sampled only in IDLE, DONE and ERROR.
REQ-008 SHALL have port entry_index  output  IDX_W  address into the external config table.
REQ-009 SHALL have port entry_addr  input  7  peripheral address of the entry at entry_index.
REQ-010 SHALL have port entry_data  input  8  data byte of the entry at entry_index.
REQ-011 SHALL have port i2c_ready  input  1  controller ready, high when idle.
REQ-012 SHALL have port i2c_enable  output  1  transaction request to the controller.
REQ-013 SHALL have port i2c_mode  output  1  always 1 (WRITE).
REQ-014 SHALL have port i2c_periph_addr  output  7  address presented to the controller.
REQ-015 SHALL have port i2c_input_byte  output  8  byte presented to the controller.
REQ-016 SHALL have port busy, done, error  output  1 each  status flags.

Function
REQ-017 SHALL implement states IDLE, FETCH, ISSUE, WAIT_ACCEPT, WAIT_DONE, GAP, DONE, ERROR.
REQ-018 IDLE/DONE/ERROR, start=1 -> FETCH: entry_index cleared to 0, done and error cleared, busy set.
REQ-019 FETCH: lasts exactly 1 clock; registers entry_addr into i2c_periph_addr and entry_data into i2c_input_byte; -> ISSUE.
REQ-020 ISSUE: i2c_enable high for exactly 2 clocks; address and byte held stable; -> WAIT_ACCEPT.
REQ-021 WAIT_ACCEPT: i2c_enable low; stays until i2c_ready=0, then -> WAIT_DONE.
REQ-022 WAIT_DONE: stays until i2c_ready=1; then -> GAP if entry_index < NUM_ENTRIES-1, else -> DONE.
REQ-023 GAP: counts GAP_CYCLES clocks, then increments entry_index and -> FETCH; GAP_CYCLES=0 means 0 idle clocks (direct -> FETCH with increment).
REQ-024 i2c_periph_addr and i2c_input_byte SHALL hold their values through WAIT_DONE; they change only in FETCH.
REQ-025 A single cycle counter SHALL be cleared on entry to WAIT_ACCEPT and on entry to WAIT_DONE; reaching TIMEOUT_CYCLES in either state -> ERROR.
REQ-026 ERROR: error=1, busy=0; entry_index holds the failing entry.
REQ-027 DONE: done=1, busy=0; entry_index holds NUM_ENTRIES-1.
REQ-028 start held high in DONE or ERROR SHALL restart the sequence; start SHALL be ignored while busy=1.
REQ-029 busy SHALL be 1 in FETCH, ISSUE, WAIT_ACCEPT, WAIT_DONE and GAP, and 0 otherwise.
REQ-030 i2c_enable SHALL be 0 in every state except ISSUE.
REQ-031 i2c_mode SHALL be constant 1 in every state, including reset.
REQ-032 entry_index SHALL never exceed NUM_ENTRIES-1 and SHALL never wrap.

Reset
REQ-033 reset=0 at any time, including mid-transaction, SHALL force state=IDLE asynchronously.
REQ-034 reset=0 SHALL set entry_index=0, i2c_enable=0, i2c_mode=1, i2c_periph_addr=0, i2c_input_byte=0, busy=0, done=0, error=0.
REQ-035 The gap and timeout counters SHALL clear asynchronously on reset=0.
REQ-036 After reset is released, the block SHALL take no action until start=1.

Verification
REQ-037 NUM_ENTRIES=3, GAP_CYCLES=2, model controller drops ready 1 clk after enable and raises it 20 clks later; start pulse -> 3 write transactions of exactly 2 enable clks each, address/data match table entries 0,1,2, done=1, error=0.
REQ-038 Controller never drops ready after enable -> error=1 exactly TIMEOUT_CYCLES clks after entry to WAIT_ACCEPT, entry_index=0, i2c_enable=0.
REQ-039 Controller holds ready=0 forever on entry 1 -> error=1 with entry_index=1; then start=1 -> sequence restarts at entry 0, error cleared.
REQ-040 reset=0 asserted during WAIT_DONE of entry 2 -> all outputs at reset values immediately (asynchronously); no further enable until a new start.
REQ-041 start held high through a whole run -> no restart while busy; after done, the held start re-launches the sequence at entry 0.
REQ-042 GAP_CYCLES=0, NUM_ENTRIES=1 -> a single write, then DONE directly from WAIT_DONE; entry_index stays 0.
